softmax_exp_engine: RTL and testbench
=====================================

// Module: softmax_exp_engine
// PURPOSE
//  Parametrised softmax front end. Buffers one VEC_LEN vector of signed scores and tracks the running max.
//  Then streams exp(x_i - x_max) per element through a one-hot match vector and a writable exp LUT,
//  and finally reports the saturating sum of all exps. Sits between the STAR data fetch and the normaliser/divider.
// PARAMETERS
//  DATA_W     8    signed input score width
//  VEC_LEN    16   elements per vector (>=2)
//  LUT_DEPTH  16   exp LUT entries; entry k = exp(-k) in fixed point
//  EXP_W      32   LUT entry / out_exp width
//  SUM_W      32   sum accumulator width
// PORTS
//  clk        in   1                  clock, posedge
//  reset      in   1                  async, active-high
//  in_valid   in   1                  score valid
//  in_ready   out  1                  engine accepts score
//  in_data    in   DATA_W             signed score
//  out_valid  out  1                  exp result valid
//  out_ready  in   1                  downstream accepts result
//  out_exp    out  EXP_W              exp(x_i - x_max)
//  out_idx    out  $clog2(VEC_LEN)    element index of out_exp
//  sum_valid  out  1                  one-cycle pulse, sum_exp valid
//  sum_exp    out  SUM_W              saturating sum of vector exps
//  lut_we     in   1                  LUT write strobe
//  lut_addr   in   $clog2(LUT_DEPTH)  LUT write address
//  lut_wdata  in   EXP_W              LUT write data
//  busy       out  1                  high outside LOAD-with-zero-count
// BEHAVIOUR
//  Reset: state=LOAD, count=0, max=most-negative, in_ready=1, out_valid=0, out_exp=0, out_idx=0,
//    sum_valid=0, sum_exp=0, busy=0. LUT contents are not cleared by reset.
//  LOAD: in_ready=1. Each in_valid&in_ready stores buf[count]=in_data, max=signed max(max,in_data), count++.
//    Accepting element VEC_LEN-1 moves to EMIT with count=0 and in_ready=0 from the next cycle.
//  EMIT: issues one element whenever !out_valid | out_ready.
//    diff = buf[k] - max, computed in DATA_W+1 bits signed (always <=0); k = -diff.
//    k <= LUT_DEPTH-1: one-hot mv = 1<<k and out_exp = lut[k]. Otherwise mv = 0, out_exp = 0 (underflow).
//    out_valid/out_exp/out_idx are registered, latency 1 cycle from issue.
//    With out_ready=0, all outputs hold stable.
//  Accumulation: sum += out_exp on each out handshake, clamped at 2^SUM_W-1 (no wrap).
//  SUM: entered after the VEC_LEN-1 handshake. sum_valid=1 for exactly 1 cycle with the final sum_exp.
//    Next cycle: LOAD, count=0, max reset, sum cleared. sum_exp holds until the next vector's first handshake.
//  LUT write: honoured only when busy=0 (LOAD, count=0); ignored otherwise. A write and the first
//    in_data handshake in the same cycle are both honoured; the new entry is used for that vector.
//  Ties for max are legal; equal maxima each give k=0.
//  Async reset mid-EMIT/SUM: outputs go to reset values immediately. Partial vector is discarded,
//    no sum_valid is produced.
// CONFIGURATION
//  SOFTMAX_UNDERFLOW_CNT_EN defined:
//    adds output underflow_cnt [$clog2(VEC_LEN+1)], the number of elements with k > LUT_DEPTH-1 in the vector.
//    Valid with sum_valid; cleared on reset and on return to LOAD.
//  Not defined: port and counter are absent; underflow elements still give out_exp=0.
// STRUCTURE
//  softmax_pkg: parameter defaults, state_t enum {LOAD,EMIT,SUM}, sat_add function.
//  Sub-module onehot_lut: LUT storage plus write port; mv one-hot in, lut entry out, 0 for all-zero mv.
// TESTING (VEC_LEN=4, LUT_DEPTH=16, lut[k]=1<<(15-k), EXP_W=SUM_W=32 unless noted)
//  1 in {3,-2,5,5} -> out_exp {8192,256,32768,32768}, idx 0..3, sum_exp=73984, one sum_valid pulse.
//  2 in {10,-10,0,0} -> out_exp {32768,0,32,32}, sum_exp=32832; underflow_cnt=1 when EN defined.
//  3 in {127,-128,127,-128} -> diffs 0,-255 -> {32768,0,32768,0}, no overflow in diff width.
//  4 SUM_W=16, in {0,0,0,0} -> sum_exp=65535 saturated (raw 131072).
//  5 out_ready low 3 cycles mid-EMIT -> out_exp/out_idx stable, no element lost or duplicated.
//  6 reset at 2nd EMIT handshake; then lut_we addr0=1 and vector {1,1,1,1} -> out_exp all 1, sum=4.

Source files
------------

// File: rtl/softmax_pkg.sv
// rtl/softmax_pkg.sv - shared defaults, FSM encoding and saturating add for softmax_exp_engine
package softmax_pkg;

   localparam int DEF_DATA_W    = 8;
   localparam int DEF_VEC_LEN   = 16;
   localparam int DEF_LUT_DEPTH = 16;
   localparam int DEF_EXP_W     = 32;
   localparam int DEF_SUM_W     = 32;

   typedef enum logic [1:0] {LOAD, EMIT, SUM} state_t;

   // Operands are zero-extended into 64 bits by the caller; max_val is the all-ones value of the target width.
   function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b,
                                           input logic [63:0] max_val);
      logic [64:0] s;
      s = {1'b0, a} + {1'b0, b};
      if (s > {1'b0, max_val})
         sat_add = max_val;
      else
         sat_add = s[63:0];
   endfunction

endpackage

// File: rtl/softmax_exp_engine_if.sv
// rtl/softmax_exp_engine_if.sv - score/exp/sum/LUT-write bundle for softmax_exp_engine
// SOFTMAX_UNDERFLOW_CNT_EN adds the underflow_cnt signal.
interface softmax_exp_engine_if
   import softmax_pkg::*;
#(
   parameter int DATA_W    = DEF_DATA_W,
   parameter int VEC_LEN   = DEF_VEC_LEN,
   parameter int LUT_DEPTH = DEF_LUT_DEPTH,
   parameter int EXP_W     = DEF_EXP_W,
   parameter int SUM_W     = DEF_SUM_W
);
   localparam int IDX_W  = $clog2(VEC_LEN);
   localparam int LUT_AW = $clog2(LUT_DEPTH);

   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              out_valid;
   logic              out_ready;
   logic [EXP_W-1:0]  out_exp;
   logic [IDX_W-1:0]  out_idx;
   logic              sum_valid;
   logic [SUM_W-1:0]  sum_exp;
   logic              lut_we;
   logic [LUT_AW-1:0] lut_addr;
   logic [EXP_W-1:0]  lut_wdata;
   logic              busy;

`ifdef SOFTMAX_UNDERFLOW_CNT_EN
   logic [$clog2(VEC_LEN+1)-1:0] underflow_cnt;

   modport master (output in_valid, in_data, out_ready, lut_we, lut_addr, lut_wdata,
                   input  in_ready, out_valid, out_exp, out_idx, sum_valid, sum_exp, busy,
                          underflow_cnt);
   modport slave  (input  in_valid, in_data, out_ready, lut_we, lut_addr, lut_wdata,
                   output in_ready, out_valid, out_exp, out_idx, sum_valid, sum_exp, busy,
                          underflow_cnt);
`else
   modport master (output in_valid, in_data, out_ready, lut_we, lut_addr, lut_wdata,
                   input  in_ready, out_valid, out_exp, out_idx, sum_valid, sum_exp, busy);
   modport slave  (input  in_valid, in_data, out_ready, lut_we, lut_addr, lut_wdata,
                   output in_ready, out_valid, out_exp, out_idx, sum_valid, sum_exp, busy);
`endif

endinterface

// File: rtl/softmax_exp_engine_onehot_lut.sv
// rtl/softmax_exp_engine_onehot_lut.sv - writable exp LUT read through a one-hot match vector
// An all-zero match vector reads as zero, which is how underflowed elements produce exp=0.
module onehot_lut #(
   parameter int LUT_DEPTH = 16,
   parameter int EXP_W     = 32,
   parameter int AW        = $clog2(LUT_DEPTH)
) (
   input  logic                 clk,
   input  logic                 we,
   input  logic [AW-1:0]        waddr,
   input  logic [EXP_W-1:0]     wdata,
   input  logic [LUT_DEPTH-1:0] mv,
   output logic [EXP_W-1:0]     rdata
);
   logic [EXP_W-1:0] mem [LUT_DEPTH];

   always_ff @(posedge clk) begin
      if (we)
         mem[waddr] <= wdata;
   end

   always_comb begin
      rdata = '0;
      for (int i = 0; i < LUT_DEPTH; i++) begin
         if (mv[i])
            rdata = rdata | mem[i];
      end
   end

endmodule

// File: rtl/softmax_exp_engine.sv
// rtl/softmax_exp_engine.sv - buffers a score vector, streams exp(x_i - x_max) and the saturating sum
// SOFTMAX_UNDERFLOW_CNT_EN adds a per-vector count of elements that fell off the end of the LUT.
module softmax_exp_engine
   import softmax_pkg::*;
#(
   parameter int DATA_W    = DEF_DATA_W,
   parameter int VEC_LEN   = DEF_VEC_LEN,
   parameter int LUT_DEPTH = DEF_LUT_DEPTH,
   parameter int EXP_W     = DEF_EXP_W,
   parameter int SUM_W     = DEF_SUM_W
) (
   input logic                clk,
   input logic                reset,
   softmax_exp_engine_if.slave bus
);
   localparam int IDX_W  = $clog2(VEC_LEN);
   localparam int DW1    = DATA_W + 1;
   localparam logic [IDX_W-1:0]         LAST     = IDX_W'(VEC_LEN - 1);
   localparam logic signed [DATA_W-1:0] MAX_INIT = {1'b1, {(DATA_W-1){1'b0}}};
   localparam logic [63:0]              SUM_MAX  = {64{1'b1}} >> (64 - SUM_W);

   state_t                   state, state_nxt;
   logic [IDX_W-1:0]         count;
   logic signed [DATA_W-1:0] max_r;
   logic signed [DATA_W-1:0] vbuf [VEC_LEN];
   logic                     all_issued;
   logic                     out_valid_r;
   logic [EXP_W-1:0]         out_exp_r;
   logic [IDX_W-1:0]         out_idx_r;
   logic [SUM_W-1:0]         sum_r;

   logic                     idle, accept, issue, out_hs, lut_wr, in_range;
   logic signed [DATA_W-1:0] cur;
   logic [DW1-1:0]           k;
   logic [LUT_DEPTH-1:0]     mv;
   logic [EXP_W-1:0]         lut_rdata;

   assign idle   = (state == LOAD) && (count == '0);
   assign accept = (state == LOAD) && bus.in_valid;
   assign issue  = (state == EMIT) && !all_issued && (!out_valid_r || bus.out_ready);
   assign out_hs = out_valid_r && bus.out_ready;
   assign lut_wr = bus.lut_we && idle;

   // k = max - x in one extra bit, so the full signed range never wraps
   assign cur      = vbuf[count];
   assign k        = {max_r[DATA_W-1], max_r} - {cur[DATA_W-1], cur};
   assign in_range = (32'(k) < 32'(LUT_DEPTH));
   assign mv       = in_range ? (LUT_DEPTH'(1) << k) : '0;

   onehot_lut #(.LUT_DEPTH(LUT_DEPTH), .EXP_W(EXP_W)) u_lut (
      .clk   (clk),
      .we    (lut_wr),
      .waddr (bus.lut_addr),
      .wdata (bus.lut_wdata),
      .mv    (mv),
      .rdata (lut_rdata)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= LOAD;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         LOAD:    if (accept && count == LAST) state_nxt = EMIT;
         EMIT:    if (out_hs && out_idx_r == LAST) state_nxt = SUM;
         SUM:     state_nxt = LOAD;
         default: state_nxt = LOAD;
      endcase
   end

   always_ff @(posedge clk) begin
      if (accept)
         vbuf[count] <= signed'(bus.in_data);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count       <= '0;
         max_r       <= MAX_INIT;
         all_issued  <= 1'b0;
         out_valid_r <= 1'b0;
         out_exp_r   <= '0;
         out_idx_r   <= '0;
         sum_r       <= '0;
      end else begin
         if (accept) begin
            if (signed'(bus.in_data) > max_r)
               max_r <= signed'(bus.in_data);
            count <= (count == LAST) ? '0 : count + IDX_W'(1);
         end
         if (issue) begin
            out_valid_r <= 1'b1;
            out_exp_r   <= lut_rdata;
            out_idx_r   <= count;
            count       <= (count == LAST) ? '0 : count + IDX_W'(1);
            if (count == LAST)
               all_issued <= 1'b1;
         end else if (out_hs) begin
            out_valid_r <= 1'b0;
         end
         // The first handshake of a vector restarts the sum, so sum_exp holds until then
         if (out_hs)
            sum_r <= SUM_W'(sat_add((out_idx_r == '0) ? 64'(0) : 64'(sum_r),
                                    64'(out_exp_r), SUM_MAX));
         if (state == SUM) begin
            max_r      <= MAX_INIT;
            all_issued <= 1'b0;
         end
      end
   end

   assign bus.in_ready  = (state == LOAD);
   assign bus.out_valid = out_valid_r;
   assign bus.out_exp   = out_exp_r;
   assign bus.out_idx   = out_idx_r;
   assign bus.sum_valid = (state == SUM);
   assign bus.sum_exp   = sum_r;
   assign bus.busy      = !idle;

`ifdef SOFTMAX_UNDERFLOW_CNT_EN
   localparam int UF_W = $clog2(VEC_LEN + 1);
   logic [UF_W-1:0] uf_cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         uf_cnt <= '0;
      else if (state == SUM)
         uf_cnt <= '0;
      else if (issue && !in_range)
         uf_cnt <= uf_cnt + UF_W'(1);
   end

   assign bus.underflow_cnt = uf_cnt;
`endif

endmodule

// File: tb/tb_softmax_exp_engine.sv
// tb/tb_softmax_exp_engine.sv - directed bench for softmax_exp_engine (VEC_LEN=4, lut[k]=1<<(15-k))
module tb_softmax_exp_engine;

   logic clk;
   logic reset;
   int   errors = 0;
   int   checks = 0;

   softmax_exp_engine_if #(.DATA_W(8), .VEC_LEN(4), .LUT_DEPTH(16), .EXP_W(32), .SUM_W(32)) bus ();
   softmax_exp_engine_if #(.DATA_W(8), .VEC_LEN(4), .LUT_DEPTH(16), .EXP_W(32), .SUM_W(16)) bus16 ();

   softmax_exp_engine #(.DATA_W(8), .VEC_LEN(4), .LUT_DEPTH(16), .EXP_W(32), .SUM_W(32)) dut (
      .clk(clk), .reset(reset), .bus(bus));
   softmax_exp_engine #(.DATA_W(8), .VEC_LEN(4), .LUT_DEPTH(16), .EXP_W(32), .SUM_W(16)) dut16 (
      .clk(clk), .reset(reset), .bus(bus16));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [31:0] mon_exp[$];
   int          mon_idx[$];
   logic [31:0] mon_sum[$];
   int          mon_uf[$];

   always @(negedge clk) begin
      if (!reset && bus.out_valid && bus.out_ready) begin
         mon_exp.push_back(bus.out_exp);
         mon_idx.push_back(int'(bus.out_idx));
      end
      if (!reset && bus.sum_valid) begin
         mon_sum.push_back(bus.sum_exp);
`ifdef SOFTMAX_UNDERFLOW_CNT_EN
         mon_uf.push_back(int'(bus.underflow_cnt));
`else
         mon_uf.push_back(0);
`endif
      end
   end

   task automatic clear_mon();
      mon_exp.delete(); mon_idx.delete(); mon_sum.delete(); mon_uf.delete();
   endtask

   task automatic load_lut();
      for (int k = 0; k < 16; k++) begin
         bus.lut_we = 1'b1; bus.lut_addr = 4'(k); bus.lut_wdata = 32'(1) << (15 - k);
         bus16.lut_we = 1'b1; bus16.lut_addr = 4'(k); bus16.lut_wdata = 32'(1) << (15 - k);
         @(posedge clk); #1;
      end
      bus.lut_we = 1'b0; bus16.lut_we = 1'b0;
   endtask

   task automatic send_vec(input int v0, input int v1, input int v2, input int v3,
                           input int wr_at, input int wa, input int wd);
      int v[4];
      v = '{v0, v1, v2, v3};
      for (int t = 0; t < 50 && !bus.in_ready; t++) begin @(posedge clk); #1; end
      for (int i = 0; i < 4; i++) begin
         bus.in_valid  = 1'b1;
         bus.in_data   = 8'(v[i]);
         bus.lut_we    = (i == wr_at);
         bus.lut_addr  = 4'(wa);
         bus.lut_wdata = 32'(wd);
         @(posedge clk); #1;
      end
      bus.in_valid = 1'b0;
      bus.lut_we   = 1'b0;
   endtask

   task automatic wait_sum(output bit got);
      got = 0;
      for (int t = 0; t < 60 && !got; t++) begin
         @(negedge clk);
         if (mon_sum.size() != 0) got = 1;
      end
      repeat (4) @(negedge clk);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus.in_valid = 0; bus.in_data = 0; bus.out_ready = 1; bus.lut_we = 0; bus.lut_addr = 0; bus.lut_wdata = 0;
      bus16.in_valid = 0; bus16.in_data = 0; bus16.out_ready = 1; bus16.lut_we = 0; bus16.lut_addr = 0; bus16.lut_wdata = 0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%0b want=1", bus.in_ready); end
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%0b want=0", bus.out_valid); end
      checks++; if (bus.out_exp !== 32'd0) begin errors++; $display("FAIL reset_out_exp got=%0d want=0", bus.out_exp); end
      checks++; if (bus.out_idx !== 2'd0) begin errors++; $display("FAIL reset_out_idx got=%0d want=0", bus.out_idx); end
      checks++; if (bus.sum_valid !== 1'b0) begin errors++; $display("FAIL reset_sum_valid got=%0b want=0", bus.sum_valid); end
      checks++; if (bus.sum_exp !== 32'd0) begin errors++; $display("FAIL reset_sum_exp got=%0d want=0", bus.sum_exp); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b want=0", bus.busy); end
   endtask

   task automatic test_basic();
      int e[4] = '{8192, 256, 32768, 32768};
      bit got;
      clear_mon();
      send_vec(3, -2, 5, 5, -1, 0, 0);
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL basic_busy got=%0b want=1", bus.busy); end
      wait_sum(got);
      checks++; if (!got || mon_exp.size() != 4) begin errors++; $display("FAIL basic_count got=%0d want=4", mon_exp.size()); end
      else begin
         for (int i = 0; i < 4; i++) begin
            checks++; if (mon_exp[i] !== 32'(e[i])) begin errors++; $display("FAIL basic_exp[%0d] got=%0d want=%0d", i, mon_exp[i], e[i]); end
            checks++; if (mon_idx[i] !== i) begin errors++; $display("FAIL basic_idx[%0d] got=%0d want=%0d", i, mon_idx[i], i); end
         end
         checks++; if (mon_sum.size() != 1) begin errors++; $display("FAIL basic_pulses got=%0d want=1", mon_sum.size()); end
         checks++; if (mon_sum[0] !== 32'd73984) begin errors++; $display("FAIL basic_sum got=%0d want=73984", mon_sum[0]); end
`ifdef SOFTMAX_UNDERFLOW_CNT_EN
         checks++; if (mon_uf[0] !== 0) begin errors++; $display("FAIL basic_uf got=%0d want=0", mon_uf[0]); end
`endif
      end
   endtask

   // also tries a LUT write while busy (count=1), which must be ignored
   task automatic test_underflow();
      int e[4] = '{32768, 0, 32, 32};
      bit got;
      clear_mon();
      send_vec(10, -10, 0, 0, 1, 10, 999);
      wait_sum(got);
      checks++; if (!got || mon_exp.size() != 4) begin errors++; $display("FAIL uflow_count got=%0d want=4", mon_exp.size()); end
      else begin
         for (int i = 0; i < 4; i++) begin
            checks++; if (mon_exp[i] !== 32'(e[i])) begin errors++; $display("FAIL uflow_exp[%0d] got=%0d want=%0d", i, mon_exp[i], e[i]); end
         end
         checks++; if (mon_sum[0] !== 32'd32832) begin errors++; $display("FAIL uflow_sum got=%0d want=32832", mon_sum[0]); end
`ifdef SOFTMAX_UNDERFLOW_CNT_EN
         checks++; if (mon_uf[0] !== 1) begin errors++; $display("FAIL uflow_cnt got=%0d want=1", mon_uf[0]); end
`endif
      end
   endtask

   task automatic test_extremes();
      int e[4] = '{32768, 0, 32768, 0};
      bit got;
      clear_mon();
      send_vec(127, -128, 127, -128, -1, 0, 0);
      wait_sum(got);
      checks++; if (!got || mon_exp.size() != 4) begin errors++; $display("FAIL extreme_count got=%0d want=4", mon_exp.size()); end
      else begin
         for (int i = 0; i < 4; i++) begin
            checks++; if (mon_exp[i] !== 32'(e[i])) begin errors++; $display("FAIL extreme_exp[%0d] got=%0d want=%0d", i, mon_exp[i], e[i]); end
         end
         checks++; if (mon_sum[0] !== 32'd65536) begin errors++; $display("FAIL extreme_sum got=%0d want=65536", mon_sum[0]); end
`ifdef SOFTMAX_UNDERFLOW_CNT_EN
         checks++; if (mon_uf[0] !== 2) begin errors++; $display("FAIL extreme_uf got=%0d want=2", mon_uf[0]); end
`endif
      end
   endtask

   task automatic test_backpressure();
      int e[4] = '{8192, 256, 32768, 32768};
      bit got, found;
      logic [31:0] snap_exp;
      logic [1:0]  snap_idx;
      clear_mon();
      found = 0;
      send_vec(3, -2, 5, 5, -1, 0, 0);
      for (int t = 0; t < 30 && !found; t++) begin
         @(negedge clk);
         if (bus.out_valid && bus.out_idx == 2'd1) found = 1;
      end
      checks++; if (!found) begin errors++; $display("FAIL bp_reach_idx1 got=0 want=1"); end
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      @(negedge clk);
      snap_exp = bus.out_exp;
      snap_idx = bus.out_idx;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         checks++; if (bus.out_exp !== snap_exp || bus.out_idx !== snap_idx || bus.out_valid !== 1'b1) begin
            errors++; $display("FAIL bp_hold[%0d] got=%0d/%0d want=%0d/%0d", c, bus.out_exp, bus.out_idx, snap_exp, snap_idx);
         end
      end
      @(posedge clk); #1;
      bus.out_ready = 1'b1;
      wait_sum(got);
      checks++; if (!got || mon_exp.size() != 4) begin errors++; $display("FAIL bp_count got=%0d want=4", mon_exp.size()); end
      else begin
         for (int i = 0; i < 4; i++) begin
            checks++; if (mon_exp[i] !== 32'(e[i]) || mon_idx[i] !== i) begin
               errors++; $display("FAIL bp_elem[%0d] got=%0d/%0d want=%0d/%0d", i, mon_exp[i], mon_idx[i], e[i], i);
            end
         end
         checks++; if (mon_sum[0] !== 32'd73984) begin errors++; $display("FAIL bp_sum got=%0d want=73984", mon_sum[0]); end
      end
   endtask

   task automatic test_sum_saturate();
      bit got;
      logic [15:0] s;
      got = 0;
      s = '0;
      for (int i = 0; i < 4; i++) begin
         bus16.in_valid = 1'b1; bus16.in_data = 8'd0;
         @(posedge clk); #1;
      end
      bus16.in_valid = 1'b0;
      for (int t = 0; t < 60 && !got; t++) begin
         @(negedge clk);
         if (bus16.sum_valid) begin got = 1; s = bus16.sum_exp; end
      end
      checks++; if (!got || s !== 16'd65535) begin errors++; $display("FAIL sat_sum got=%0d want=65535", s); end
   endtask

   task automatic test_reset_mid_emit();
      bit got, found;
      clear_mon();
      found = 0;
      send_vec(1, 2, 3, 4, -1, 0, 0);
      for (int t = 0; t < 30 && !found; t++) begin
         @(negedge clk);
         if (bus.out_valid && bus.out_idx == 2'd1) found = 1;
      end
      checks++; if (!found) begin errors++; $display("FAIL rst_reach_idx1 got=0 want=1"); end
      #2 reset = 1'b1;
      #1;
      checks++; if (bus.out_valid !== 1'b0 || bus.out_exp !== 32'd0 || bus.out_idx !== 2'd0) begin
         errors++; $display("FAIL rst_async_out got=%0b/%0d/%0d want=0/0/0", bus.out_valid, bus.out_exp, bus.out_idx);
      end
      checks++; if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0 || bus.sum_valid !== 1'b0) begin
         errors++; $display("FAIL rst_async_ctl got=%0b/%0b/%0b want=1/0/0", bus.in_ready, bus.busy, bus.sum_valid);
      end
      @(negedge clk);
      reset = 1'b0;
      clear_mon();
      repeat (8) @(negedge clk);
      checks++; if (mon_sum.size() != 0 || mon_exp.size() != 0) begin
         errors++; $display("FAIL rst_no_sum got=%0d want=0", mon_sum.size());
      end
      send_vec(1, 1, 1, 1, 0, 0, 1);
      wait_sum(got);
      checks++; if (!got || mon_exp.size() != 4) begin errors++; $display("FAIL rst_vec_count got=%0d want=4", mon_exp.size()); end
      else begin
         for (int i = 0; i < 4; i++) begin
            checks++; if (mon_exp[i] !== 32'd1) begin errors++; $display("FAIL rst_vec_exp[%0d] got=%0d want=1", i, mon_exp[i]); end
         end
         checks++; if (mon_sum[0] !== 32'd4) begin errors++; $display("FAIL rst_vec_sum got=%0d want=4", mon_sum[0]); end
      end
   endtask

   initial begin
      test_reset();
      load_lut();
      test_basic();
      test_underflow();
      test_extremes();
      test_backpressure();
      test_sum_saturate();
      test_reset_mid_emit();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
